// File: rtl/scope_pkg.sv
// scope_pkg: shared types and constants for the scope history display path
package scope_pkg;
  typedef logic [3:0] row_code_t;
  typedef struct packed {
    row_code_t q1;
    row_code_t q2;
  } col_entry_t;
  localparam int RGB_R1 = 5;
  localparam int RGB_G1 = 4;
  localparam int RGB_B1 = 3;
  localparam int RGB_R2 = 2;
  localparam int RGB_G2 = 1;
  localparam int RGB_B2 = 0;
  localparam logic [2:0] CENTER_ROW = 3'd7;
  function automatic row_code_t quantise(input logic [11:0] p);
    return 4'd15 - p[11:8];
  endfunction
endpackage

// File: rtl/load_edge_sync.sv
// load_edge_sync: 2-FF synchroniser on an idle-high strobe plus falling-edge pulse
module load_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic fall
);
  logic [2:0] sr;
  assign fall = sr[2] && !sr[1];
  // sr[0..1] synchronise, sr[2] remembers the previous synchronised level
  always_ff @(posedge clk or posedge reset)
    if (reset) sr <= 3'b111;
    else sr <= {sr[1:0], d};
endmodule

// File: rtl/scope_history.sv
// scope_history: two-channel scrolling waveform history for the LED panel (grid overlay under SCOPE_GRID_EN)
module scope_history import scope_pkg::*; #(
  parameter int COLS  = 32,
  parameter int DECIM = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [11:0]             p1data,
  input  logic [11:0]             p2data,
  input  logic                    frame_start,
  input  logic                    hold,
  input  logic [$clog2(COLS)-1:0] rd_col,
  input  logic [2:0]              rd_row,
  output logic [5:0]              rgb,
  output logic                    overrun
);
  localparam int AW = $clog2(COLS);
  localparam int DW = DECIM > 1 ? $clog2(DECIM) : 1;
  logic cap, accept, take, commit, pend_valid;
  logic r1, g1, r2, g2;
  logic [DW-1:0] dcnt;
  logic [AW-1:0] wr_ptr, idx;
  logic [COLS-1:0] col_valid;
  logic [5:0] rgb_d;
  col_entry_t pend, ent;
  col_entry_t mem [COLS];
  load_edge_sync u_sync (.clk(clk), .reset(reset), .d(load), .fall(cap));
  assign accept = cap && dcnt == '0;
  assign take   = accept && !hold;
  assign commit = frame_start && pend_valid && !hold;
  assign idx    = wr_ptr + rd_col;
  assign ent    = mem[idx];
  assign r1     = col_valid[idx] && ent.q1 == {1'b0, rd_row};
  assign g1     = col_valid[idx] && ent.q2 == {1'b0, rd_row};
  assign r2     = col_valid[idx] && ent.q1 == {1'b1, rd_row};
  assign g2     = col_valid[idx] && ent.q2 == {1'b1, rd_row};
  // decimation, pending entry, overrun flag and commit bookkeeping
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      dcnt       <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      overrun    <= 1'b0;
      wr_ptr     <= '0;
      col_valid  <= '0;
    end else begin
      if (cap) dcnt <= dcnt == DW'(DECIM - 1) ? '0 : dcnt + 1'b1;
      if (take) pend <= {quantise(p1data), quantise(p2data)};
      pend_valid <= take || (pend_valid && !commit);
      overrun    <= overrun || (take && pend_valid && !commit);
      if (commit) begin
        wr_ptr            <= wr_ptr + 1'b1;
        col_valid[wr_ptr] <= 1'b1;
      end
    end
  // column storage; stale contents are hidden by col_valid so no reset is needed
  always_ff @(posedge clk)
    if (commit) mem[wr_ptr] <= pend;
  // pixel decode for the top and bottom half rows
  always_comb begin
    rgb_d = '0;
    rgb_d[RGB_R1] = r1;
    rgb_d[RGB_G1] = g1;
    rgb_d[RGB_R2] = r2;
    rgb_d[RGB_G2] = g2;
`ifdef SCOPE_GRID_EN
    rgb_d[RGB_B1] = rd_row == CENTER_ROW && !r1 && !g1;
    rgb_d[RGB_B2] = rd_col[2:0] == 3'd0 && !r2 && !g2;
`endif
  end
  // registered read port: one pixel per clock, one cycle latency
  always_ff @(posedge clk or posedge reset)
    if (reset) rgb <= '0;
    else rgb <= rgb_d;
endmodule

// File: tb/tb_scope_history.sv
// tb_scope_history: directed self-checking bench for scope_history (default build, grid off)
module tb_scope_history;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load = 1'b1;
  logic [11:0] p1data = '0;
  logic [11:0] p2data = '0;
  logic frame_start = 1'b0;
  logic hold = 1'b0;
  logic [4:0] rd_col = '0;
  logic [2:0] rd_row = '0;
  logic [5:0] rgb, rgb3;
  logic overrun, overrun3;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  scope_history #(.COLS(32), .DECIM(1)) dut (
    .clk(clk), .reset(reset), .load(load), .p1data(p1data), .p2data(p2data),
    .frame_start(frame_start), .hold(hold), .rd_col(rd_col), .rd_row(rd_row),
    .rgb(rgb), .overrun(overrun)
  );

  scope_history #(.COLS(32), .DECIM(3)) dut3 (
    .clk(clk), .reset(reset), .load(load), .p1data(p1data), .p2data(p2data),
    .frame_start(frame_start), .hold(hold), .rd_col(rd_col), .rd_row(rd_row),
    .rgb(rgb3), .overrun(overrun3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    load = 1'b1;
    frame_start = 1'b0;
    hold = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic pulse_load(input logic [11:0] a, input logic [11:0] b);
    p1data = a;
    p2data = b;
    load = 1'b0;
    repeat (4) tick();
    load = 1'b1;
    repeat (3) tick();
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
  endtask

  task automatic read(input int col, input int row);
    rd_col = col[4:0];
    rd_row = row[2:0];
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    total++;
    if (rgb !== 6'b0) begin bad++; $display("FAIL reset_rgb got=%b want=%b", rgb, 6'b0); end
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    do_reset();
    read(31, 0);
    total++;
    if (rgb !== 6'b0) begin bad++; $display("FAIL reset_read got=%b want=%b", rgb, 6'b0); end
  endtask

  task automatic test_single();
    do_reset();
    pulse_load(12'hFFF, 12'h000);
    read(31, 0);
    total++;
    if (rgb !== 6'b0) begin bad++; $display("FAIL single_no_bypass got=%b want=%b", rgb, 6'b0); end
    frame();
    read(31, 0);
    total++;
    if (rgb !== 6'b100000) begin bad++; $display("FAIL single_r1 got=%b want=%b", rgb, 6'b100000); end
    read(31, 7);
    total++;
    if (rgb !== 6'b000010) begin bad++; $display("FAIL single_g2 got=%b want=%b", rgb, 6'b000010); end
    read(30, 0);
    total++;
    if (rgb !== 6'b0) begin bad++; $display("FAIL single_col30_r0 got=%b want=%b", rgb, 6'b0); end
    read(30, 7);
    total++;
    if (rgb !== 6'b0) begin bad++; $display("FAIL single_col30_r7 got=%b want=%b", rgb, 6'b0); end
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL single_overrun got=%b want=0", overrun); end
  endtask

  task automatic test_scroll();
    int cols [5] = '{0, 1, 15, 30, 31};
    do_reset();
    for (int n = 0; n <= 32; n++) begin
      pulse_load(12'((n % 16) << 8), 12'h000);
      frame();
    end
    foreach (cols[i]) begin
      int c, q1, row;
      logic [5:0] want;
      c = cols[i];
      q1 = 15 - ((c + 1) % 16);
      row = q1 % 8;
      want = (q1 < 8 ? 6'b100000 : 6'b000100) | (row == 7 ? 6'b000010 : 6'b0);
      read(c, row);
      total++;
      if (rgb !== want) begin bad++; $display("FAIL scroll_col%0d got=%b want=%b", c, rgb, want); end
    end
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL scroll_overrun got=%b want=0", overrun); end
  endtask

  task automatic test_overrun();
    do_reset();
    pulse_load(12'hFFF, 12'h000);
    pulse_load(12'h300, 12'hFFF);
    total++;
    if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_set got=%b want=1", overrun); end
    frame();
    read(31, 4);
    total++;
    if (rgb !== 6'b000100) begin bad++; $display("FAIL overrun_second_r2 got=%b want=%b", rgb, 6'b000100); end
    read(31, 0);
    total++;
    if (rgb !== 6'b010000) begin bad++; $display("FAIL overrun_second_g1 got=%b want=%b", rgb, 6'b010000); end
    read(30, 0);
    total++;
    if (rgb !== 6'b0) begin bad++; $display("FAIL overrun_first_dropped got=%b want=%b", rgb, 6'b0); end
    do_reset();
    pulse_load(12'hFFF, 12'h000);
    p1data = 12'h300;
    p2data = 12'hFFF;
    load = 1'b0;
    tick();
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    load = 1'b1;
    repeat (3) tick();
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_coincident got=%b want=0", overrun); end
    frame();
    read(31, 0);
    total++;
    if (rgb !== 6'b010000) begin bad++; $display("FAIL coincident_second got=%b want=%b", rgb, 6'b010000); end
    read(30, 0);
    total++;
    if (rgb !== 6'b100000) begin bad++; $display("FAIL coincident_first got=%b want=%b", rgb, 6'b100000); end
    read(29, 0);
    total++;
    if (rgb !== 6'b0) begin bad++; $display("FAIL coincident_col29 got=%b want=%b", rgb, 6'b0); end
  endtask

  task automatic test_hold();
    do_reset();
    pulse_load(12'hFFF, 12'h000);
    frame();
    hold = 1'b1;
    for (int n = 0; n < 5; n++) begin
      pulse_load(12'h300, 12'hFFF);
      frame();
    end
    hold = 1'b0;
    frame();
    for (int c = 0; c < 32; c++) begin
      logic [5:0] want;
      want = c == 31 ? 6'b100000 : 6'b0;
      read(c, 0);
      total++;
      if (rgb !== want) begin bad++; $display("FAIL hold_col%0d got=%b want=%b", c, rgb, want); end
    end
    read(31, 4);
    total++;
    if (rgb !== 6'b0) begin bad++; $display("FAIL hold_no_new got=%b want=%b", rgb, 6'b0); end
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL hold_overrun got=%b want=0", overrun); end
  endtask

  task automatic test_decim();
    do_reset();
    for (int n = 0; n < 6; n++) begin
      pulse_load(12'(n << 8), 12'h000);
      frame();
    end
    read(31, 4);
    total++;
    if (rgb3 !== 6'b000100) begin bad++; $display("FAIL decim_t3 got=%b want=%b", rgb3, 6'b000100); end
    read(31, 3);
    total++;
    if (rgb3 !== 6'b0) begin bad++; $display("FAIL decim_t4_absent got=%b want=%b", rgb3, 6'b0); end
    read(30, 7);
    total++;
    if (rgb3 !== 6'b000110) begin bad++; $display("FAIL decim_t0 got=%b want=%b", rgb3, 6'b000110); end
    read(29, 7);
    total++;
    if (rgb3 !== 6'b0) begin bad++; $display("FAIL decim_col29 got=%b want=%b", rgb3, 6'b0); end
    total++;
    if (overrun3 !== 1'b0) begin bad++; $display("FAIL decim_overrun got=%b want=0", overrun3); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pulse_load(12'hFFF, 12'h000);
    #2 reset = 1'b1;
    #3 reset = 1'b0;
    tick();
    frame();
    read(31, 0);
    total++;
    if (rgb !== 6'b0) begin bad++; $display("FAIL reset_mid_r0 got=%b want=%b", rgb, 6'b0); end
    read(31, 7);
    total++;
    if (rgb !== 6'b0) begin bad++; $display("FAIL reset_mid_r7 got=%b want=%b", rgb, 6'b0); end
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL reset_mid_overrun got=%b want=0", overrun); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_scroll();
    test_overrun();
    test_hold();
    test_decim();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
